seq_divider: RTL and testbench



---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider.
// The master drives the operands and enable; the slave returns the quotient, remainder and status.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             enable_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;
    logic             busy_o;
    logic             finish_o;

    modport master (
        output enable_i, dividend_i, divisor_i,
        input  quotient_o, remainder_o, div_by_zero_o, busy_o, finish_o
    );

    modport slave (
        input  enable_i, dividend_i, divisor_i,
        output quotient_o, remainder_o, div_by_zero_o, busy_o, finish_o
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUB/CHECK pass,
// with a level enable/finish handshake and registers cleared whenever the FSM is idle.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input logic          clk_i,
    input logic          reset_i,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        SUB    = 3'd3,
        CHECK  = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    cnt;
    logic             dbz;

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:   state_next = bus.enable_i ? START : IDLE;
            START:  state_next = (m_reg == '0) ? FINISH : SHIFT;
            SHIFT:  state_next = SUB;
            SUB:    state_next = CHECK;
            CHECK:  state_next = (cnt == CW'(1)) ? FINISH : SHIFT;
            FINISH: state_next = bus.enable_i ? FINISH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: every path back into IDLE clears the registers so IDLE outputs read zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    a_reg <= '0;
                    q_reg <= bus.enable_i ? bus.dividend_i : '0;
                    m_reg <= bus.enable_i ? bus.divisor_i : '0;
                    cnt   <= bus.enable_i ? CW'(WIDTH) : '0;
                    dbz   <= 1'b0;
                end
                START: begin
                    if (m_reg == '0) begin
                        dbz   <= 1'b1;
                        a_reg <= {1'b0, q_reg};
                        q_reg <= '1;
                    end
                end
                SHIFT: begin
                    a_reg <= {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
                    q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                end
                SUB: a_reg <= a_reg - {1'b0, m_reg};
                CHECK: begin
                    // Negative partial remainder means the divisor did not fit: restore it.
                    if (a_reg[WIDTH]) begin
                        a_reg    <= a_reg + {1'b0, m_reg};
                        q_reg[0] <= 1'b0;
                    end else begin
                        q_reg[0] <= 1'b1;
                    end
                    cnt <= cnt - CW'(1);
                end
                FINISH: begin
                    if (!bus.enable_i) begin
                        a_reg <= '0;
                        q_reg <= '0;
                        m_reg <= '0;
                        cnt   <= '0;
                        dbz   <= 1'b0;
                    end
                end
                default: begin
                    a_reg <= '0;
                    q_reg <= '0;
                    m_reg <= '0;
                    cnt   <= '0;
                    dbz   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy_o        = (state == START) || (state == SHIFT) ||
                            (state == SUB)   || (state == CHECK);
        bus.finish_o      = (state == FINISH);
        bus.quotient_o    = q_reg;
        bus.remainder_o   = a_reg[WIDTH-1:0];
        bus.div_by_zero_o = dbz && (state == FINISH);
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and randomised bench for seq_divider (WIDTH=8).
module tb_seq_divider;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dd;
        logic [7:0] dv;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Presents operands and enable, then returns just after edge E0.
    task automatic start_op(input logic [7:0] dd, input logic [7:0] dv);
        @(negedge clk);
        bus.dividend_i = dd;
        bus.divisor_i  = dv;
        bus.enable_i   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Counts edges after E0 until finish_o is seen, bounded at 100.
    task automatic wait_finish(output int n);
        n = 0;
        while (!bus.finish_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_and_check(input string name);
        @(negedge clk);
        bus.enable_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " idle finish"}, int'(bus.finish_o), 0);
        check({name, " idle busy"}, int'(bus.busy_o), 0);
        check({name, " idle q"}, int'(bus.quotient_o), 0);
        check({name, " idle r"}, int'(bus.remainder_o), 0);
    endtask

    initial begin
        int n;
        logic [7:0] dd, dv;
        int k;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0};
        vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0};
        vecs[5] = '{8'd128, 8'd2,   8'd64,  8'd0};
        vecs[6] = '{8'd200, 8'd13,  8'd15,  8'd5};
        vecs[7] = '{8'd1,   8'd2,   8'd0,   8'd1};
        vecs[8] = '{8'd254, 8'd127, 8'd2,   8'd0};

        bus.enable_i   = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(bus.busy_o), 0);
        check("reset finish", int'(bus.finish_o), 0);
        check("reset q", int'(bus.quotient_o), 0);
        check("reset r", int'(bus.remainder_o), 0);
        check("reset dbz", int'(bus.div_by_zero_o), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].dd, vecs[i].dv);
            check($sformatf("vec%0d busy", i), int'(bus.busy_o), 1);
            wait_finish(n);
            check($sformatf("vec%0d latency", i), n, 25);
            check($sformatf("vec%0d q", i), int'(bus.quotient_o), int'(vecs[i].q));
            check($sformatf("vec%0d r", i), int'(bus.remainder_o), int'(vecs[i].r));
            check($sformatf("vec%0d dbz", i), int'(bus.div_by_zero_o), 0);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("vec%0d hold finish", i), int'(bus.finish_o), 1);
            check($sformatf("vec%0d hold q", i), int'(bus.quotient_o), int'(vecs[i].q));
            check($sformatf("vec%0d hold r", i), int'(bus.remainder_o), int'(vecs[i].r));
            release_and_check($sformatf("vec%0d", i));
        end

        // Divide by zero
        start_op(8'd200, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("dbz finish", int'(bus.finish_o), 1);
        check("dbz flag", int'(bus.div_by_zero_o), 1);
        check("dbz q", int'(bus.quotient_o), 255);
        check("dbz r", int'(bus.remainder_o), 200);
        release_and_check("dbz");
        check("dbz flag cleared", int'(bus.div_by_zero_o), 0);

        // Operand changes after E0 must not affect the result
        start_op(8'd60, 8'd8);
        repeat (6) begin
            @(negedge clk);
            bus.dividend_i = 8'($urandom);
            bus.divisor_i  = 8'($urandom);
        end
        wait_finish(n);
        check("toggle finish", int'(bus.finish_o), 1);
        check("toggle q", int'(bus.quotient_o), 7);
        check("toggle r", int'(bus.remainder_o), 4);
        release_and_check("toggle");

        // Reset mid-operation at E0+10
        start_op(8'd77, 8'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.enable_i = 1'b0;
        @(posedge clk);
        #1;
        check("midreset busy", int'(bus.busy_o), 0);
        check("midreset finish", int'(bus.finish_o), 0);
        check("midreset q", int'(bus.quotient_o), 0);
        check("midreset r", int'(bus.remainder_o), 0);
        @(negedge clk);
        reset = 1'b0;
        start_op(8'd77, 8'd5);
        wait_finish(n);
        check("post-reset latency", n, 25);
        check("post-reset q", int'(bus.quotient_o), 15);
        check("post-reset r", int'(bus.remainder_o), 2);
        release_and_check("post-reset");

        // Random regression against the division invariant
        for (int i = 0; i < 2000; i++) begin
            dd = 8'($urandom);
            dv = 8'($urandom_range(1, 255));
            start_op(dd, dv);
            if (i % 100 == 0) begin
                k = $urandom_range(1, 20);
                repeat (k) @(posedge clk);
                @(negedge clk);
                bus.enable_i = 1'b0;
                #1;
                wait_finish(n);
                check("drop finish seen", int'(bus.finish_o), 1);
                check("drop invariant",
                      int'(bus.quotient_o) * int'(dv) + int'(bus.remainder_o), int'(dd));
                @(posedge clk);
                #1;
                check("drop single finish", int'(bus.finish_o), 0);
                check("drop idle busy", int'(bus.busy_o), 0);
            end else begin
                wait_finish(n);
                check("rand invariant",
                      int'(bus.quotient_o) * int'(dv) + int'(bus.remainder_o), int'(dd));
                check("rand r<d", int'(bus.remainder_o < dv), 1);
                @(negedge clk);
                bus.enable_i = 1'b0;
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
